// File: rtl/led_pkg.sv
// Shared definitions for the LED sweep sequencer: FSM state encoding and LED position width.
package led_pkg;

  localparam int LED_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/led_tick_prescaler.sv
// Step-rate prescaler: counts 0..div while enabled and flags the terminal count as tick.
module led_tick_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  // Tick coincides with the terminal count so div=0 steps on every enabled cycle.
  assign tick = en && (count == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/led_sweep_ctrl.sv
// LED position sweep sequencer: bounces pos between latched lo/hi bounds for a
// programmed number of round trips, one step per prescaler tick.
module led_sweep_ctrl
  import led_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CYC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [LED_W-1:0] cfg_lo,
  input  logic [LED_W-1:0] cfg_hi,
  input  logic [CYC_W-1:0] cfg_cycles,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [LED_W-1:0] pos,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYC_W-1:0] cycle_cnt
);

  state_t           state, state_nxt;
  logic [LED_W-1:0] pos_nxt;
  logic             dir_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             err_nxt;
  logic [CYC_W-1:0] cnt_nxt;
  logic [CYC_W-1:0] cnt_inc;

  logic [LED_W-1:0] lo_s, lo_nxt;
  logic [LED_W-1:0] hi_s, hi_nxt;
  logic [CYC_W-1:0] cycles_s, cycles_nxt;
  logic [DIV_W-1:0] div_s, div_nxt;

  logic             pre_clr;
  logic             pre_en;
  logic             tick;

  assign cnt_inc = cycle_cnt + 1'b1;
  assign pre_en  = (state == S_UP) || (state == S_DOWN);

  led_tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .div  (div_s),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pos       <= '0;
      dir       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cycle_cnt <= '0;
      lo_s      <= '0;
      hi_s      <= '0;
      cycles_s  <= '0;
      div_s     <= '0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      dir       <= dir_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      cycle_cnt <= cnt_nxt;
      lo_s      <= lo_nxt;
      hi_s      <= hi_nxt;
      cycles_s  <= cycles_nxt;
      div_s     <= div_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos;
    dir_nxt    = dir;
    cnt_nxt    = cycle_cnt;
    err_nxt    = 1'b0;
    lo_nxt     = lo_s;
    hi_nxt     = hi_s;
    cycles_nxt = cycles_s;
    div_nxt    = div_s;
    pre_clr    = 1'b0;

    case (state)
      S_IDLE: begin
        // Stop outranks start; an inverted range is refused without touching pos.
        if (!stop && start) begin
          if (cfg_lo > cfg_hi) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt  = S_UP;
            pos_nxt    = cfg_lo;
            dir_nxt    = 1'b1;
            cnt_nxt    = '0;
            lo_nxt     = cfg_lo;
            hi_nxt     = cfg_hi;
            cycles_nxt = cfg_cycles;
            div_nxt    = cfg_div;
            pre_clr    = 1'b1;
          end
        end
      end
      S_UP: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          if (pos < hi_s) begin
            pos_nxt = pos + 1'b1;
          end else begin
            state_nxt = S_DOWN;
            dir_nxt   = 1'b0;
          end
        end
      end
      S_DOWN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          if (pos > lo_s) begin
            pos_nxt = pos - 1'b1;
          end else begin
            // Dwell at the low bound closes one round trip.
            cnt_nxt = cnt_inc;
            if ((cycles_s != '0) && (cnt_inc == cycles_s)) begin
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_UP;
              dir_nxt   = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt == S_UP) || (state_nxt == S_DOWN);
    done_nxt = (state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Scoreboard bench for led_sweep_ctrl: expected per-cycle pos/dir/busy/done/cycle_cnt
// tuples are queued from an independent sweep model and popped as the DUT advances.
module tb_led_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] cfg_lo = '0;
  logic [4:0] cfg_hi = '0;
  logic [3:0] cfg_cycles = '0;
  logic [7:0] cfg_div = '0;
  logic [4:0] pos;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] cycle_cnt;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [4:0] pos;
    logic       dir;
    logic       busy;
    logic       done;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];

  led_sweep_ctrl #(.DIV_W(8), .CYC_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cfg_lo     (cfg_lo),
    .cfg_hi     (cfg_hi),
    .cfg_cycles (cfg_cycles),
    .cfg_div    (cfg_div),
    .pos        (pos),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int p, input int d, input int b, input int dn, input int c);
    exp_t e;
    e.pos  = p[4:0];
    e.dir  = d[0];
    e.busy = b[0];
    e.done = dn[0];
    e.cnt  = c[3:0];
    sb.push_back(e);
  endtask

  // Each round trip visits lo..hi going up, then hi..lo going down, one tick per visit,
  // each tick lasting div+1 cycles.
  task automatic push_trips(input int lo, input int hi, input int div, input int first, input int n);
    for (int r = 0; r < n; r++) begin
      for (int k = 0; k <= 2 * (hi - lo) + 1; k++) begin
        int p;
        int d;
        if (k <= hi - lo) begin
          p = lo + k;
          d = 1;
        end else begin
          p = hi - (k - (hi - lo + 1));
          d = 0;
        end
        for (int c = 0; c <= div; c++) push_exp(p, d, 1, 0, (first + r) % 16);
      end
    end
  endtask

  task automatic push_end(input int lo, input int cycles);
    push_exp(lo, 0, 0, 1, cycles);
    push_exp(lo, 0, 0, 0, cycles);
  endtask

  task automatic launch(input int lo, input int hi, input int cyc, input int div);
    cfg_lo     = lo[4:0];
    cfg_hi     = hi[4:0];
    cfg_cycles = cyc[3:0];
    cfg_div    = div[7:0];
    start      = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    e = '{pos: 5'd0, dir: 1'b1, busy: 1'b0, done: 1'b0, cnt: 4'd0};
    step_clk();
    n_checks++;
    if ({pos, dir, busy, done, cycle_cnt} !== e || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold got pos=%0d dir=%b busy=%b done=%b err=%b cnt=%0d, want 0 1 0 0 0 0",
               pos, dir, busy, done, err, cycle_cnt);
    end
    rst = 1'b1;
    step_clk();
    n_checks++;
    if ({pos, dir, busy, done, cycle_cnt} !== e || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got pos=%0d dir=%b busy=%b done=%b err=%b cnt=%0d, want 0 1 0 0 0 0",
               pos, dir, busy, done, err, cycle_cnt);
    end
  endtask

  task automatic test_single_trip();
    exp_t e;
    int   i;
    sb.delete();
    push_trips(3, 5, 0, 0, 1);
    push_end(3, 1);
    launch(3, 5, 1, 0);
    i = 0;
    while (sb.size() > 0) begin
      step_clk();
      start = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({pos, dir, busy, done, cycle_cnt} !== e) begin
        n_fail++;
        $display("FAIL single_trip[%0d] got pos=%0d dir=%b busy=%b done=%b cnt=%0d, want pos=%0d dir=%b busy=%b done=%b cnt=%0d",
                 i, pos, dir, busy, done, cycle_cnt, e.pos, e.dir, e.busy, e.done, e.cnt);
      end
      i++;
    end
  endtask

  task automatic test_prescale();
    exp_t e;
    int   i;
    sb.delete();
    push_trips(0, 1, 2, 0, 2);
    push_end(0, 2);
    launch(0, 1, 2, 2);
    i = 0;
    while (sb.size() > 0) begin
      step_clk();
      start = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({pos, dir, busy, done, cycle_cnt} !== e) begin
        n_fail++;
        $display("FAIL prescale[%0d] got pos=%0d dir=%b busy=%b done=%b cnt=%0d, want pos=%0d dir=%b busy=%b done=%b cnt=%0d",
                 i, pos, dir, busy, done, cycle_cnt, e.pos, e.dir, e.busy, e.done, e.cnt);
      end
      i++;
    end
  endtask

  task automatic test_degenerate();
    exp_t e;
    int   i;
    sb.delete();
    push_trips(7, 7, 0, 0, 1);
    push_end(7, 1);
    launch(7, 7, 1, 0);
    i = 0;
    while (sb.size() > 0) begin
      step_clk();
      start = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({pos, dir, busy, done, cycle_cnt} !== e) begin
        n_fail++;
        $display("FAIL degenerate[%0d] got pos=%0d dir=%b busy=%b done=%b cnt=%0d, want pos=%0d dir=%b busy=%b done=%b cnt=%0d",
                 i, pos, dir, busy, done, cycle_cnt, e.pos, e.dir, e.busy, e.done, e.cnt);
      end
      i++;
    end
  endtask

  task automatic test_error();
    launch(9, 4, 1, 0);
    step_clk();
    start = 1'b0;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || pos !== 5'd7) begin
      n_fail++;
      $display("FAIL err_pulse got err=%b busy=%b pos=%0d, want err=1 busy=0 pos=7", err, busy, pos);
    end
    step_clk();
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0 || pos !== 5'd7) begin
      n_fail++;
      $display("FAIL err_clear got err=%b busy=%b pos=%0d, want err=0 busy=0 pos=7", err, busy, pos);
    end
  endtask

  task automatic test_start_stop_idle();
    launch(1, 3, 1, 0);
    stop = 1'b1;
    step_clk();
    n_checks++;
    if (busy !== 1'b0 || pos !== 5'd7 || err !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_idle got busy=%b pos=%0d err=%b done=%b, want busy=0 pos=7 err=0 done=0",
               busy, pos, err, done);
    end
    start = 1'b0;
    stop  = 1'b0;
    step_clk();
    n_checks++;
    if (busy !== 1'b0 || pos !== 5'd7) begin
      n_fail++;
      $display("FAIL start_stop_after got busy=%b pos=%0d, want busy=0 pos=7", busy, pos);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int   i;
    sb.delete();
    push_trips(2, 6, 0, 0, 2);
    for (int p = 2; p <= 5; p++) push_exp(p, 1, 1, 0, 2);
    launch(2, 6, 0, 0);
    i = 0;
    while (sb.size() > 0) begin
      step_clk();
      start = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({pos, dir, busy, done, cycle_cnt} !== e) begin
        n_fail++;
        $display("FAIL abort_run[%0d] got pos=%0d dir=%b busy=%b done=%b cnt=%0d, want pos=%0d dir=%b busy=%b done=%b cnt=%0d",
                 i, pos, dir, busy, done, cycle_cnt, e.pos, e.dir, e.busy, e.done, e.cnt);
      end
      i++;
    end
    // pos=5 rising with a tick pending: stop must win.
    stop = 1'b1;
    step_clk();
    stop = 1'b0;
    n_checks++;
    if (pos !== 5'd5 || dir !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cycle_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL abort_stop got pos=%0d dir=%b busy=%b done=%b cnt=%0d, want 5 1 0 0 2",
               pos, dir, busy, done, cycle_cnt);
    end
    step_clk();
    n_checks++;
    if (pos !== 5'd5 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after got pos=%0d busy=%b done=%b, want 5 0 0", pos, busy, done);
    end
  endtask

  task automatic test_cfg_isolation();
    exp_t e;
    int   i;
    sb.delete();
    push_trips(0, 6, 0, 0, 1);
    push_end(0, 1);
    launch(0, 6, 1, 0);
    i = 0;
    while (sb.size() > 0) begin
      step_clk();
      start = 1'b0;
      if (i == 2) begin
        cfg_hi     = 5'd10;
        cfg_lo     = 5'd1;
        cfg_cycles = 4'd3;
        cfg_div    = 8'd4;
      end
      e = sb.pop_front();
      n_checks++;
      if ({pos, dir, busy, done, cycle_cnt} !== e) begin
        n_fail++;
        $display("FAIL cfg_isolation[%0d] got pos=%0d dir=%b busy=%b done=%b cnt=%0d, want pos=%0d dir=%b busy=%b done=%b cnt=%0d",
                 i, pos, dir, busy, done, cycle_cnt, e.pos, e.dir, e.busy, e.done, e.cnt);
      end
      i++;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   i;
    launch(4, 9, 0, 1);
    step_clk();
    start = 1'b0;
    step_clk();
    step_clk();
    n_checks++;
    if (pos !== 5'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset got pos=%0d busy=%b, want pos=5 busy=1", pos, busy);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (pos !== 5'd0 || dir !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cycle_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset got pos=%0d dir=%b busy=%b done=%b err=%b cnt=%0d, want 0 1 0 0 0 0",
               pos, dir, busy, done, err, cycle_cnt);
    end
    step_clk();
    rst = 1'b1;
    step_clk();
    n_checks++;
    if (pos !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got pos=%0d busy=%b done=%b, want 0 0 0", pos, busy, done);
    end
    sb.delete();
    push_trips(1, 2, 0, 0, 1);
    push_end(1, 1);
    launch(1, 2, 1, 0);
    i = 0;
    while (sb.size() > 0) begin
      step_clk();
      start = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({pos, dir, busy, done, cycle_cnt} !== e) begin
        n_fail++;
        $display("FAIL restart[%0d] got pos=%0d dir=%b busy=%b done=%b cnt=%0d, want pos=%0d dir=%b busy=%b done=%b cnt=%0d",
                 i, pos, dir, busy, done, cycle_cnt, e.pos, e.dir, e.busy, e.done, e.cnt);
      end
      i++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_trip();
    test_prescale();
    test_degenerate();
    test_error();
    test_start_stop_idle();
    test_abort();
    test_cfg_isolation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
